// File: rtl/fft_mult_pkg.sv
// ----------------------------------------------------------------------------
// fft_mult_pkg
// Shared constants and arithmetic helpers for the FFT multiplier datapath.
// Used by stream_mult_pipe and intended for reuse by the butterfly.
//
// Contents:
//   MULT_W_DEF / MULT_PIPE_DEF / MULT_FRAC_DEF : default parameter values
//   MULT_ACC_W                                 : working width for rounding
//   round_shift()                              : round-half-up right shift
// ----------------------------------------------------------------------------
package fft_mult_pkg;

   localparam int MULT_W_DEF    = 16;
   localparam int MULT_PIPE_DEF = 3;
   localparam int MULT_FRAC_DEF = 15;

   // Rounding is done in a wide accumulator so that adding the half-LSB term
   // can never wrap, whatever the product. Supports products up to 126 bits.
   localparam int MULT_ACC_W = 128;
   localparam logic [MULT_ACC_W-1:0] MULT_ACC_ONE = {{(MULT_ACC_W-1){1'b0}}, 1'b1};

   // (product + 2^(frac-1)) >> frac, arithmetic shift for signed operands.
   // The caller sign- or zero-extends its product into MULT_ACC_W bits.
   function automatic logic [MULT_ACC_W-1:0] round_shift(
      input logic [MULT_ACC_W-1:0] product,
      input int unsigned           frac,
      input logic                  is_signed
   );
      logic [MULT_ACC_W-1:0] biased;
      logic [MULT_ACC_W-1:0] shifted;
      if (frac == 32'd0) begin
         biased = product;
      end else begin
         biased = product + (MULT_ACC_ONE << (frac - 32'd1));
      end
      if (is_signed) begin
         shifted = $unsigned($signed(biased) >>> frac);
      end else begin
         shifted = biased >> frac;
      end
      return shifted;
   endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// ----------------------------------------------------------------------------
// mult_pipe_stage
// One register stage of the stream multiplier: a data register plus a valid
// bit. The stage loads whenever it is empty or its current beat moves on,
// which lets beats collapse into empty stages (bubble removal).
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   prev_data   : data offered by the previous stage (or the input)
//   prev_valid  : previous stage holds a beat
//   next_ready  : the next stage (or downstream) takes a beat this cycle
//   data, valid : registered contents of this stage
// ----------------------------------------------------------------------------
module mult_pipe_stage
   import fft_mult_pkg::*;
#(
   parameter int DW = 2 * MULT_W_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [DW-1:0] prev_data,
   input  logic          prev_valid,
   input  logic          next_ready,
   output logic [DW-1:0] data,
   output logic          valid
);

   logic load;

   assign load = ~valid | next_ready;

   // Stage register: take the upstream beat when empty or advancing.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
         data  <= {DW{1'b0}};
      end else if (load) begin
         valid <= prev_valid;
         // Keep the old data when a bubble moves in, so the output only
         // toggles on real beats.
         if (prev_valid) begin
            data <= prev_data;
         end
      end
   end

endmodule

// File: rtl/stream_mult_pipe.sv
// ----------------------------------------------------------------------------
// stream_mult_pipe
// Pipelined fixed-point multiplier with valid/ready streams on both sides.
// Each input beat is {a, b}; each output beat is the 2W-bit product, or the
// Q-format rounded product when built with MULT_ROUND_EN defined.
//
// Parameters: W (operand width), PIPE (>= 1 register stages),
//             SIGNED (1 = two's complement), FRAC_BITS (round shift, 0..2W-1)
// Build option: MULT_ROUND_EN -> round-half-up shift by FRAC_BITS in the
//             last stage; otherwise the raw product is emitted.
//
// Ports:
//   i_clk, i_rst_n         : clock, asynchronous active-low reset
//   i_data, i_data_valid   : input beat {a, b} and its valid
//   o_data_ready           : block accepts a beat this cycle
//   o_data, o_data_valid   : output beat, taken straight from the last stage
//   i_data_ready           : downstream accepts a beat this cycle
// ----------------------------------------------------------------------------
module stream_mult_pipe
   import fft_mult_pkg::*;
#(
   parameter int W         = MULT_W_DEF,
   parameter int PIPE      = MULT_PIPE_DEF,
   parameter int SIGNED    = 1,
   parameter int FRAC_BITS = MULT_FRAC_DEF
) (
   input  logic           i_clk,
   input  logic           i_rst_n,
   input  logic [2*W-1:0] i_data,
   input  logic           i_data_valid,
   output logic           o_data_ready,
   output logic [2*W-1:0] o_data,
   output logic           o_data_valid,
   input  logic           i_data_ready
);

   localparam int   DW        = 2 * W;
   localparam int   EXT_W     = MULT_ACC_W - DW;
   localparam logic IS_SIGNED = (SIGNED != 0);
`ifdef MULT_ROUND_EN
   localparam logic ROUND_EN  = 1'b1;
`else
   localparam logic ROUND_EN  = 1'b0;
`endif

   logic [W-1:0]  op_a;
   logic [W-1:0]  op_b;
   logic [DW-1:0] ext_a;
   logic [DW-1:0] ext_b;
   logic [DW-1:0] last_in;

   // Index 0 is the input side (product of the incoming beat).
   logic [DW-1:0] stage_data [0:PIPE];
   logic [PIPE:0] stage_valid;
   // chain_ready[k] = stage k loads this cycle; PIPE+1 is downstream.
   logic [PIPE+1:1] chain_ready;

   // Operand split and full-width multiply. Extending both operands to 2W
   // first makes the low 2W bits of the product exact for either signedness,
   // including -2^(W-1) * -2^(W-1).
   always_comb begin
      op_a  = i_data[DW-1:W];
      op_b  = i_data[W-1:0];
      ext_a = {{W{IS_SIGNED & op_a[W-1]}}, op_a};
      ext_b = {{W{IS_SIGNED & op_b[W-1]}}, op_b};
      stage_data[0] = ext_a * ext_b;
   end

   assign stage_valid[0] = i_data_valid;

   // Rounding sits on the input of the last stage so latency is unchanged.
   always_comb begin
      if (ROUND_EN) begin
         last_in = DW'(round_shift(
            {{EXT_W{IS_SIGNED & stage_data[PIPE-1][DW-1]}}, stage_data[PIPE-1]},
            FRAC_BITS, IS_SIGNED));
      end else begin
         last_in = stage_data[PIPE-1];
      end
   end

   // Ready chain: a stage loads if it is empty or the stage after it loads.
   always_comb begin
      chain_ready = {(PIPE+1){1'b0}};
      chain_ready[PIPE+1] = i_data_ready;
      for (int k = PIPE; k >= 1; k--) begin
         chain_ready[k] = ~stage_valid[k] | chain_ready[k+1];
      end
   end

   for (genvar k = 1; k <= PIPE; k++) begin : g_stage
      logic [DW-1:0] stage_in;
      if (k == PIPE) begin : g_last
         assign stage_in = last_in;
      end else begin : g_mid
         assign stage_in = stage_data[k-1];
      end

      mult_pipe_stage #(
         .DW (DW)
      ) u_stage (
         .clk        (i_clk),
         .rst_n      (i_rst_n),
         .prev_data  (stage_in),
         .prev_valid (stage_valid[k-1]),
         .next_ready (chain_ready[k+1]),
         .data       (stage_data[k]),
         .valid      (stage_valid[k])
      );
   end

   assign o_data       = stage_data[PIPE];
   assign o_data_valid = stage_valid[PIPE];
   assign o_data_ready = chain_ready[1];

endmodule

// File: tb/tb_stream_mult_pipe.sv
// ----------------------------------------------------------------------------
// tb_stream_mult_pipe
// Self-checking bench for stream_mult_pipe. Main instance: W=16, PIPE=3,
// SIGNED=1. Second instance: PIPE=1, SIGNED=0. Expected values come from a
// plain-arithmetic model and a queue of in-flight beats. MULT_ROUND_EN
// selects the rounded expectations (FRAC_BITS = 8).
// ----------------------------------------------------------------------------
module tb_stream_mult_pipe;

   localparam int P    = 3;
   localparam int FRAC = 8;

   logic        clk       = 1'b0;
   logic        rst_n     = 1'b0;
   logic [31:0] in_data   = 32'h0;
   logic        in_valid  = 1'b0;
   logic        dut_ready;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b1;

   logic [31:0] u1_in_data   = 32'h0;
   logic        u1_in_valid  = 1'b0;
   logic        u1_ready;
   logic [31:0] u1_out_data;
   logic        u1_out_valid;
   logic        u1_out_ready = 1'b1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   stream_mult_pipe #(.W(16), .PIPE(P), .SIGNED(1), .FRAC_BITS(FRAC)) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(in_data), .i_data_valid(in_valid),
      .o_data_ready(dut_ready), .o_data(out_data), .o_data_valid(out_valid),
      .i_data_ready(out_ready)
   );

   stream_mult_pipe #(.W(16), .PIPE(1), .SIGNED(0), .FRAC_BITS(FRAC)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(u1_in_data), .i_data_valid(u1_in_valid),
      .o_data_ready(u1_ready), .o_data(u1_out_data), .o_data_valid(u1_out_valid),
      .i_data_ready(u1_out_ready)
   );

   // Reference: exact integer product, optionally rounded half up.
   function automatic logic [31:0] model(input logic [15:0] a, input logic [15:0] b,
                                         input bit sgn);
      longint sa, sb, x;
      sa = sgn ? longint'(signed'(a)) : longint'(a);
      sb = sgn ? longint'(signed'(b)) : longint'(b);
      x  = sa * sb;
`ifdef MULT_ROUND_EN
      x = (x + (longint'(1) <<< (FRAC - 1))) >>> FRAC;
`endif
      return x[31:0];
   endfunction

   task automatic test_reset();
      #100;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
      checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got %h want 0", out_data); end
      checks++; if (dut_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", dut_ready); end
      checks++; if (u1_out_valid !== 1'b0 || u1_ready !== 1'b1) begin errors++;
         $display("FAIL reset_u1 got valid=%b ready=%b want 0/1", u1_out_valid, u1_ready); end
      @(negedge clk); rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got %b want 0", out_valid); end
   endtask

   task automatic test_latency(input logic [15:0] a, input logic [15:0] b);
      logic [31:0] want;
      want = model(a, b, 1'b1);
      @(posedge clk); #1;
      in_data = {a, b}; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      checks++; if (dut_ready !== 1'b1) begin errors++; $display("FAIL lat_accept got %b want 1", dut_ready); end
      @(posedge clk); #1; in_valid = 1'b0;
      for (int c = 0; c < P; c++) begin
         if (c > 0) @(posedge clk);
         @(negedge clk);
         checks++;
         if (out_valid !== (c == P - 1)) begin errors++;
            $display("FAIL lat_valid edge+%0d got %b want %b", c, out_valid, (c == P - 1)); end
      end
      checks++; if (out_data !== want) begin errors++;
         $display("FAIL lat_data a=%h b=%h got %h want %h", a, b, out_data, want); end
   endtask

   task automatic test_corners();
      logic [15:0] ta [5];
      logic [15:0] tb [5];
      logic [31:0] te [5];
`ifdef MULT_ROUND_EN
      ta = '{16'h0100, 16'h0001, 16'hFFFF, 16'h0001, 16'h8000};
      tb = '{16'h0180, 16'h0080, 16'h0080, 16'h007F, 16'h8000};
      te = '{32'h00000180, 32'h00000001, 32'h00000000, 32'h00000000, 32'h00400000};
`else
      ta = '{16'hFFFD, 16'h8000, 16'h7FFF, 16'h8000, 16'h0005};
      tb = '{16'h0007, 16'h8000, 16'h7FFF, 16'h7FFF, 16'h0006};
      te = '{32'hFFFFFFEB, 32'h40000000, 32'h3FFF0001, 32'hC0008000, 32'h0000001E};
`endif
      for (int i = 0; i < 5; i++) begin
         int waited;
         @(posedge clk); #1;
         in_data = {ta[i], tb[i]}; in_valid = 1'b1; out_ready = 1'b1;
         @(posedge clk); #1; in_valid = 1'b0;
         waited = 0;
         @(negedge clk);
         while (out_valid !== 1'b1 && waited < 20) begin @(negedge clk); waited++; end
         checks++;
         if (out_valid !== 1'b1) begin errors++; $display("FAIL corner_timeout %0d got no valid want valid", i); end
         else if (out_data !== te[i]) begin errors++;
            $display("FAIL corner_%0d a=%h b=%h got %h want %h", i, ta[i], tb[i], out_data, te[i]); end
      end
   endtask

   task automatic test_bubble();
      logic [15:0] ba [3];
      logic [15:0] bb [3];
      ba = '{16'd2, 16'd4, 16'd6};
      bb = '{16'd3, 16'd5, 16'd7};
      @(posedge clk); #1; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = {ba[i], bb[i]}; in_valid = 1'b1;
         @(negedge clk);
         checks++; if (dut_ready !== 1'b1) begin errors++; $display("FAIL bubble_accept %0d got %b want 1", i, dut_ready); end
         @(posedge clk); #1;
      end
      in_data = {16'd9, 16'd9};
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (dut_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== model(ba[0], bb[0], 1'b1)) begin errors++;
            $display("FAIL bubble_full got ready=%b valid=%b data=%h want 0/1/%h",
                     dut_ready, out_valid, out_data, model(ba[0], bb[0], 1'b1)); end
      end
      @(posedge clk); #1; in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (out_valid !== 1'b1 || out_data !== model(ba[i], bb[i], 1'b1)) begin errors++;
            $display("FAIL bubble_drain %0d got valid=%b data=%h want 1/%h",
                     i, out_valid, out_data, model(ba[i], bb[i], 1'b1)); end
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bubble_empty got %b want 0", out_valid); end
   endtask

   task automatic test_stream(input int nbeats, input bit rnd);
      logic [15:0] ga [];
      logic [15:0] gb [];
      logic [31:0] exp_q [$];
      logic [31:0] want, prev_data;
      logic        want_ready;
      bit          prev_stall;
      int          sent, recv, budget, held;
      ga = new[nbeats];
      gb = new[nbeats];
      for (int i = 0; i < nbeats; i++) begin
         if (rnd) begin
            ga[i] = 16'($urandom); gb[i] = 16'($urandom);
         end else begin
            ga[i] = 16'(i); gb[i] = 16'(i + 1);
         end
      end
      sent = 0; recv = 0; budget = 0; prev_stall = 1'b0; prev_data = 32'h0;
      while ((sent < nbeats || recv < nbeats) && budget < nbeats * 20 + 100) begin
         @(posedge clk); #1;
         if (sent < nbeats) begin
            in_data  = {ga[sent], gb[sent]};
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         held = exp_q.size();
         want_ready = (held < P) || out_ready;
         checks++; if (dut_ready !== want_ready) begin errors++;
            $display("FAIL stream_ready held=%0d got %b want %b", held, dut_ready, want_ready); end
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== prev_data) begin errors++;
               $display("FAIL stream_hold got valid=%b data=%h want 1/%h", out_valid, out_data, prev_data); end
         end
         if (held == 0) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_spurious got %b want 0", out_valid); end
         end else if (out_valid === 1'b1 && out_ready) begin
            want = exp_q.pop_front();
            checks++; if (out_data !== want) begin errors++;
               $display("FAIL stream_data beat %0d got %h want %h", recv, out_data, want); end
            recv++;
         end
         prev_stall = (out_valid === 1'b1) && !out_ready;
         prev_data  = out_data;
         if (in_valid && dut_ready === 1'b1) begin
            exp_q.push_back(model(ga[sent], gb[sent], 1'b1));
            sent++;
         end
         budget++;
      end
      checks++; if (recv != nbeats) begin errors++; $display("FAIL stream_count got %0d want %0d", recv, nbeats); end
      in_valid = 1'b0; out_ready = 1'b1;
   endtask

   task automatic test_unsigned();
      logic [31:0] ua [3];
      logic [31:0] ue [3];
      ua = '{32'hFFFF0002, 32'hFFFFFFFF, 32'h12340010};
`ifdef MULT_ROUND_EN
      ue = '{32'h00000200, 32'h00FFFE00, 32'h00000123};
`else
      ue = '{32'h0001FFFE, 32'hFFFE0001, 32'h00012340};
`endif
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         u1_in_data = ua[i]; u1_in_valid = 1'b1; u1_out_ready = 1'b1;
         @(negedge clk);
         checks++; if (u1_ready !== 1'b1) begin errors++; $display("FAIL u1_accept got %b want 1", u1_ready); end
         @(posedge clk); #1; u1_in_valid = 1'b0;
         @(negedge clk);
         checks++;
         if (u1_out_valid !== 1'b1 || u1_out_data !== ue[i]) begin errors++;
            $display("FAIL u1_data %0d got valid=%b data=%h want 1/%h", i, u1_out_valid, u1_out_data, ue[i]); end
         @(negedge clk);
         checks++; if (u1_out_valid !== 1'b0) begin errors++; $display("FAIL u1_empty got %b want 0", u1_out_valid); end
      end
   endtask

   task automatic test_async_reset();
      @(posedge clk); #1; out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_data = {16'(i + 1), 16'd3}; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL areset_inflight got %b want 1", out_valid); end
      @(posedge clk); #3; rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 32'h0 || dut_ready !== 1'b1) begin errors++;
         $display("FAIL areset_clear got valid=%b data=%h ready=%b want 0/0/1", out_valid, out_data, dut_ready); end
      @(negedge clk); #2; rst_n = 1'b1;
      test_latency(16'd2, 16'd3);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_latency(16'd5, 16'd6);
      repeat (3) test_latency(16'($urandom), 16'($urandom));
      test_corners();
      test_bubble();
      test_stream(10, 1'b0);
      test_stream(200, 1'b1);
      test_unsigned();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/stream_mult_pipe.md
Name: stream_mult_pipe

Overview:
Parametrised, pipelined fixed-point multiplier with a valid/ready stream on both sides. It is the next generation of the FFT peripheral's single-lane multiplier. Each input beat packs two operands {a, b}; each output beat carries the product, full width or Q-format rounded. Full backpressure, bubble collapse and selectable signedness make it usable as the twiddle-multiply primitive inside the FFT butterfly datapath.

Parameters:
W, 16, operand width in bits; each input beat is {a[W-1:0], b[W-1:0]}, a in the upper half
PIPE, 3, number of register stages from input to output; must be >= 1
SIGNED, 1, 1 = two's-complement operands and product; 0 = unsigned
FRAC_BITS, 15, right shift applied when MULT_ROUND_EN is defined; must be in 0..2W-1

Ports:
i_clk  in  1  clock; all registers rise-edge triggered
i_rst_n  in  1  asynchronous active-low reset
i_data  in  2W  packed operands {a, b}
i_data_valid  in  1  upstream beat valid
o_data_ready  out  1  block can accept a beat this cycle
o_data  out  2W  product (or rounded product), sign- or zero-extended to 2W
o_data_valid  out  1  output beat valid
i_data_ready  in  1  downstream can accept a beat

Behaviour:
- Reset (async assert, sync-safe deassert): every stage valid bit = 0, o_data_valid = 0, o_data = 0. o_data_ready follows stage emptiness, so it is 1 during reset.
- Transfers occur on a rising edge where valid && ready, on each side independently.
- Pipeline is PIPE stages S1..SPIPE. Each stage holds a data register and a valid bit. o_data / o_data_valid come directly from SPIPE registers; there is no combinational path from i_data to o_data.
- Stage k loads from stage k-1 (S1 loads from input) when k is empty or k advances. SPIPE advances when i_data_ready = 1. Empty stages therefore collapse bubbles.
- o_data_ready = S1 empty OR S1 advances. This is a combinational chain from i_data_ready; this path is accepted.
- Latency: a beat accepted at edge n is presented (o_data_valid = 1) after edge n+PIPE-1 when nothing stalls. With PIPE = 1, o_data_valid rises after the accept edge itself.
- Throughput: one beat per cycle when i_data_ready is held high.
- Stall: when i_data_ready = 0 and o_data_valid = 1, o_data holds stable. Upstream fills up to PIPE beats, then o_data_ready drops.
- Simultaneous accept and emit with a full pipe: legal, no loss, no duplication.
- Order is preserved; no beat is dropped or repeated.
- Arithmetic: SIGNED = 1 gives $signed(a)*$signed(b) in a 2W-bit result. The case -2^(W-1) * -2^(W-1) = +2^(2W-2) fits and must be exact. SIGNED = 0 gives an unsigned 2W-bit product.
- Multiplier placement within the stages is free; only latency and values are specified.
- Async reset mid-stream discards all in-flight beats immediately; after release the block behaves as after power-on.

Optional Feature:
MULT_ROUND_EN
- Defined: o_data = (product + 2^(FRAC_BITS-1)) >>> FRAC_BITS, round half up. The shift is arithmetic when SIGNED = 1, logical otherwise. The result is sign/zero-extended to 2W. When FRAC_BITS = 0 there is no rounding term. Latency is unchanged; rounding is absorbed inside SPIPE.
- Undefined: o_data = raw 2W product; FRAC_BITS is ignored.

Decomposition:
- Package fft_mult_pkg holds:
  - default constants MULT_W_DEF = 16, MULT_PIPE_DEF = 3, MULT_FRAC_DEF = 15;
  - a function round_shift(product, frac, signed) shared with the future butterfly.
- One sub-module, mult_pipe_stage: a single register stage with valid bit and the load/advance rule, parametrised by data width. It is instantiated PIPE times via generate.

Test Plan:
1. W=16, SIGNED=1, no round; reset 100 ns, then {16'd5, 16'd6} valid with i_data_ready = 1 -> o_data = 32'h0000001E, valid exactly PIPE-1 edges after accept.
2. Signed corners: {-3, 7} -> 32'hFFFFFFEB; {16'h8000, 16'h8000} -> 32'h40000000; {16'h7FFF, 16'h7FFF} -> 32'h3FFF0001. SIGNED=0 with {16'hFFFF, 16'h0002} -> 32'h0001FFFE.
3. Backpressure: stream 10 beats a=i, b=i+1 while i_data_ready toggles randomly. Expect outputs i*(i+1) in order, no loss. o_data is stable while stalled, and o_data_ready = 0 exactly when PIPE beats are held and i_data_ready = 0.
4. Bubble collapse, PIPE=3: one beat accepted while i_data_ready = 0, then 2 more beats. Expect all 3 held, then o_data_ready low. Raising i_data_ready drains them on 3 consecutive cycles.
5. MULT_ROUND_EN, FRAC_BITS=8, SIGNED=1: {16'h0100, 16'h0180} -> 32'h00000180; {1, 16'h0080} -> 1; {-1, 16'h0080} -> 0; {1, 16'h007F} -> 0.
6. Reset mid-stream: assert i_rst_n = 0 with 3 beats in flight, asynchronous to the clock. Expect o_data_valid = 0 and o_data = 0 immediately. After release, a new beat {2, 3} produces 6 with no stale output.
